// File: rtl/srff_arb_ctrl.sv
// Round-robin arbiter that gives four requesters a shared SR flip-flop bank.
// Latency: gnt 1 cycle after req; q/done/err 2 cycles after gnt. The granted requester keeps gnt until it drops req.
// Optional saturating conflict counter is built only when SRFF_ARB_ERRCNT_EN is defined.
module srff_arb_ctrl #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] s_bus,
   input  logic [NREQ*WIDTH-1:0] r_bus,
   output logic [NREQ-1:0]       gnt,
   output logic                  done,
   output logic                  err,
   output logic [WIDTH-1:0]      q,
   output logic [WIDTH-1:0]      qbar,
   output logic [7:0]            err_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_APPLY = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       gnt_idx;
   logic [1:0]       last_gnt;
   logic [1:0]       pick_idx;
   logic [1:0]       cand;
   logic             pick_vld;
   logic [WIDTH-1:0] s_lat;
   logic [WIDTH-1:0] r_lat;
   logic [WIDTH-1:0] s_sel;
   logic [WIDTH-1:0] r_sel;
   logic [WIDTH-1:0] set_m;
   logic [WIDTH-1:0] rst_m;
   logic             conflict;

   // Search starts one past the last winner; k==4 wraps back onto last_gnt itself.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = last_gnt;
      cand     = last_gnt;
      for (int k = 1; k <= 4; k++) begin
         cand = last_gnt + 2'(k);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      s_sel    = s_bus[int'(gnt_idx)*WIDTH +: WIDTH];
      r_sel    = r_bus[int'(gnt_idx)*WIDTH +: WIDTH];
      // S=R=1 bits are excluded from both masks so they hold their value.
      set_m    = s_lat & ~r_lat;
      rst_m    = r_lat & ~s_lat;
      conflict = |(s_lat & r_lat);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         gnt_idx  <= 2'd0;
         last_gnt <= 2'd3;
         s_lat    <= '0;
         r_lat    <= '0;
         q        <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  gnt     <= NREQ'(1) << pick_idx;
                  gnt_idx <= pick_idx;
                  state   <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               s_lat <= s_sel;
               r_lat <= r_sel;
               state <= ST_APPLY;
            end
            ST_APPLY: begin
               q     <= (q & ~rst_m) | set_m;
               done  <= 1'b1;
               err   <= conflict;
               state <= ST_HOLD;
            end
            default: begin
               if (!req[gnt_idx]) begin
                  gnt      <= '0;
                  last_gnt <= gnt_idx;
                  state    <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign qbar = ~q;

`ifdef SRFF_ARB_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (clear) begin
         err_cnt <= 8'd0;
      end else if (state == ST_APPLY && conflict && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_srff_arb_ctrl.sv
// Scoreboard bench for srff_arb_ctrl: stimulus pushes expected results, a negedge monitor checks each done pulse.
module tb_srff_arb_ctrl;

   logic        clk;
   logic        clear;
   logic [3:0]  req;
   logic [31:0] s_bus;
   logic [31:0] r_bus;
   logic [3:0]  gnt;
   logic        done;
   logic        err;
   logic [7:0]  q;
   logic [7:0]  qbar;
   logic [7:0]  err_cnt;

   srff_arb_ctrl #(.WIDTH(8), .NREQ(4)) dut (
      .clk     (clk),
      .clear   (clear),
      .req     (req),
      .s_bus   (s_bus),
      .r_bus   (r_bus),
      .gnt     (gnt),
      .done    (done),
      .err     (err),
      .q       (q),
      .qbar    (qbar),
      .err_cnt (err_cnt)
   );

   typedef struct packed {
      logic [3:0] gnt;
      logic [7:0] q;
      logic       err;
      logic [7:0] ecnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [7:0]  mon_qb;
   int          checks = 0;
   int          passes = 0;
   logic [7:0]  exp_ecnt = 8'd0;
   int          n;
   int          idx;
   logic [3:0]  oh;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
   endtask

   function automatic void bump();
`ifdef SRFF_ARB_ERRCNT_EN
      if (exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'd1;
`endif
   endfunction

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            mon_e  = sb.pop_front();
            mon_qb = ~mon_e.q;
            chk("mon_gnt", {28'd0, gnt}, {28'd0, mon_e.gnt});
            chk("mon_q", {24'd0, q}, {24'd0, mon_e.q});
            chk("mon_qbar", {24'd0, qbar}, {24'd0, mon_qb});
            chk("mon_err", {31'd0, err}, {31'd0, mon_e.err});
            chk("mon_err_cnt", {24'd0, err_cnt}, {24'd0, mon_e.ecnt});
         end
      end else if (err === 1'b1) begin
         chk("err_without_done", {31'd0, err}, 32'd0);
      end
   end

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      clear    = 1'b0;
      exp_ecnt = 8'd0;
   endtask

   task automatic txn(input int i, input logic [7:0] s, input logic [7:0] r,
                      input logic [7:0] exp_q, input bit cf);
      int         c;
      logic [3:0] h;
      h = 4'b0001 << i;
      @(negedge clk);
      s_bus[i*8 +: 8] = s;
      r_bus[i*8 +: 8] = r;
      req[i]          = 1'b1;
      if (cf) bump();
      sb.push_back(exp_t'{h, exp_q, cf, exp_ecnt});
      @(posedge clk); #1;
      chk("txn_gnt", {28'd0, gnt}, {28'd0, h});
      wait_done(c);
      chk("txn_latency", c, 2);
      @(negedge clk);
      req[i] = 1'b0;
      @(posedge clk); #1;
      chk("txn_release", {28'd0, gnt}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      clear = 1'b1;
      req   = 4'b0000;
      s_bus = 32'd0;
      r_bus = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", {28'd0, gnt}, 32'd0);
      chk("rst_q", {24'd0, q}, 32'd0);
      chk("rst_qbar", {24'd0, qbar}, 32'hFF);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      @(negedge clk);
      clear = 1'b0;

      // Basic set from requester 0, then requester 3 leaves last_gnt at 3.
      txn(0, 8'h0F, 8'h00, 8'h0F, 1'b0);
      txn(3, 8'h0F, 8'h00, 8'h0F, 1'b0);

      // Round robin with all four requesting.
      @(negedge clk);
      s_bus = 32'h08040201;
      r_bus = 32'd0;
      req   = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         idx = k % 4;
         oh  = 4'b0001 << idx;
         sb.push_back(exp_t'{oh, 8'h0F, 1'b0, exp_ecnt});
         n = 0;
         while (gnt === 4'b0000 && n < 10) begin
            @(posedge clk); #1;
            n++;
         end
         chk("rr_gnt", {28'd0, gnt}, {28'd0, oh});
         wait_done(n);
         chk("rr_latency", n, 2);
         @(negedge clk);
         req[idx] = 1'b0;
         @(posedge clk); #1;
         chk("rr_release", {28'd0, gnt}, 32'd0);
         @(negedge clk);
         if (k < 4) req[idx] = 1'b1;
         else req = 4'b0000;
      end
      chk("rr_final_q", {24'd0, q}, 32'h0F);

      // Conflicting masks: S=R=1 bits hold.
      pulse_clear();
      txn(2, 8'hFF, 8'h0F, 8'hF0, 1'b1);
`ifdef SRFF_ARB_ERRCNT_EN
      chk("errcnt_one", {24'd0, err_cnt}, 32'd1);
`else
      chk("errcnt_one", {24'd0, err_cnt}, 32'd0);
`endif

      // Clear during APPLY discards the update.
      @(negedge clk);
      s_bus[7:0] = 8'hAA;
      r_bus[7:0] = 8'h00;
      req        = 4'b0001;
      @(posedge clk); #1;
      chk("abort_gnt", {28'd0, gnt}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      chk("abort_q", {24'd0, q}, 32'h00);
      chk("abort_gnt_clr", {28'd0, gnt}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      clear    = 1'b0;
      req      = 4'b0000;
      exp_ecnt = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      s_bus = 32'hFF00003C;
      r_bus = 32'd0;
      req   = 4'b1001;
      sb.push_back(exp_t'{4'b0001, 8'h3C, 1'b0, exp_ecnt});
      @(posedge clk); #1;
      chk("post_clear_gnt", {28'd0, gnt}, 32'h1);
      wait_done(n);
      chk("post_clear_latency", n, 2);
      @(negedge clk);
      req = 4'b0000;
      @(posedge clk); #1;
      chk("post_clear_release", {28'd0, gnt}, 32'd0);

      // Mask change after the latch edge is ignored; long hold keeps gnt.
      pulse_clear();
      @(negedge clk);
      s_bus = 32'h00000001;
      r_bus = 32'd0;
      req   = 4'b0001;
      sb.push_back(exp_t'{4'b0001, 8'h01, 1'b0, exp_ecnt});
      @(posedge clk); #1;
      chk("late_gnt", {28'd0, gnt}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      s_bus[7:0] = 8'hFF;
      wait_done(n);
      chk("late_latency", n, 1);
      @(negedge clk);
      s_bus[15:8] = 8'h80;
      req[1]      = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold_gnt", {28'd0, gnt}, 32'h1);
         chk("hold_q", {24'd0, q}, 32'h01);
      end
      sb.push_back(exp_t'{4'b0010, 8'h81, 1'b0, exp_ecnt});
      @(negedge clk);
      req[0] = 1'b0;
      @(posedge clk); #1;
      chk("hold_exit", {28'd0, gnt}, 32'd0);
      @(posedge clk); #1;
      chk("waiter_gnt", {28'd0, gnt}, 32'h2);
      wait_done(n);
      chk("waiter_latency", n, 2);
      @(negedge clk);
      req = 4'b0000;
      @(posedge clk); #1;
      chk("waiter_release", {28'd0, gnt}, 32'd0);

      // Counter saturation over 300 conflicting transactions.
      for (int t = 0; t < 300; t++) begin
         txn(0, 8'hFF, 8'hFF, 8'h81, 1'b1);
      end
`ifdef SRFF_ARB_ERRCNT_EN
      chk("errcnt_sat", {24'd0, err_cnt}, 32'd255);
`else
      chk("errcnt_sat", {24'd0, err_cnt}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
